// File: rtl/riscv_pkg.sv
// Shared RV32I constants and types for the fetch/decode slice of the pipeline.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Major opcodes, shared with the control unit
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic {
    FS_BOOT,
    FS_RUN
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of {pc, instr} pairs between the fetch response path and IF/ID.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    push,
  input  logic [XLEN-1:0]         push_pc,
  input  logic [XLEN-1:0]         push_instr,
  input  logic                    pop,
  output logic [XLEN-1:0]         head_pc,
  output logic [XLEN-1:0]         head_instr,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end

  always_comb begin
    head_pc    = pc_mem[rd_ptr];
    head_instr = instr_mem[rd_ptr];
    full       = (count == CW'(DEPTH));
    empty      = (count == '0);
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: PC generation, credit-limited imem requests,
// in-order response tagging and the IF/ID output register with stall/redirect.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = INSTR_NOP
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  typedef logic [CW-1:0] cnt_t;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  cnt_t            live_q, discard_q;
  logic            accept, rsp_live, rsp_drop, credit_ok;
  logic [CW:0]     q_plus_live, live_plus_disc;

  logic            q_push, q_pop, q_full, q_empty;
  logic [XLEN-1:0] q_head_pc, q_head_instr;
  cnt_t            q_count;

  logic [XLEN-1:0] tag_mem [DEPTH];
  logic [AW-1:0]   tag_wr, tag_rd;
  logic [XLEN-1:0] rsp_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FS_BOOT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FS_BOOT: state_d = FS_RUN;
      FS_RUN:  state_d = FS_RUN;
    endcase
  end

  always_comb begin
    q_plus_live    = {1'b0, q_count} + {1'b0, live_q};
    live_plus_disc = {1'b0, live_q} + {1'b0, discard_q};
    credit_ok      = (q_plus_live < (CW+1)'(DEPTH)) && (live_plus_disc < (CW+1)'(DEPTH));
    imem_req       = (state_q == FS_RUN) && credit_ok;
    imem_addr      = pc_q;
    accept         = imem_req && imem_ready;
    rsp_drop       = imem_rvalid && (discard_q != '0);
    rsp_live       = imem_rvalid && (discard_q == '0);
    rsp_pc         = tag_mem[tag_rd];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= word_align(redirect_pc);
    end else if (accept) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  // On redirect every outstanding request becomes a discard, including one
  // accepted this cycle; a same-cycle response retires one of them either way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q    <= '0;
      discard_q <= '0;
    end else if (redirect_valid) begin
      live_q    <= '0;
      discard_q <= discard_q + live_q + cnt_t'(accept) - cnt_t'(imem_rvalid);
    end else begin
      live_q    <= live_q + cnt_t'(accept) - cnt_t'(rsp_live);
      discard_q <= discard_q - cnt_t'(rsp_drop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_wr <= '0;
      tag_rd <= '0;
    end else if (redirect_valid) begin
      tag_wr <= '0;
      tag_rd <= '0;
    end else begin
      if (accept)   tag_wr <= tag_wr + AW'(1);
      if (rsp_live) tag_rd <= tag_rd + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !redirect_valid) tag_mem[tag_wr] <= pc_q;
  end

  always_comb begin
    q_pop  = !redirect_valid && !stall && !q_empty;
    q_push = !redirect_valid && rsp_live && (stall || !q_empty);
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .clear      (redirect_valid),
    .push       (q_push),
    .push_pc    (rsp_pc),
    .push_instr (imem_rdata),
    .pop        (q_pop),
    .head_pc    (q_head_pc),
    .head_instr (q_head_instr),
    .count      (q_count),
    .full       (q_full),
    .empty      (q_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid    <= 1'b0;
      if_instr    <= NOP_INSTR;
      if_pc       <= RESET_PC;
      if_pc_plus4 <= RESET_PC + 32'd4;
    end else if (redirect_valid) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
    end else if (!stall) begin
      if (!q_empty) begin
        if_valid    <= 1'b1;
        if_instr    <= q_head_instr;
        if_pc       <= q_head_pc;
        if_pc_plus4 <= q_head_pc + 32'd4;
      end else if (rsp_live) begin
        if_valid    <= 1'b1;
        if_instr    <= imem_rdata;
        if_pc       <= rsp_pc;
        if_pc_plus4 <= rsp_pc + 32'd4;
      end else begin
        if_valid <= 1'b0;
        if_instr <= NOP_INSTR;
      end
    end
  end

  // The issue credit keeps queue occupancy plus live requests within DEPTH.
  assert property (@(posedge clk) disable iff (rst) !(q_push && q_full && !q_pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model plus an expected-PC-stream
// model of the IF/ID output, with literal checks on timing and boundary cases.
module tb_fetch_unit;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid, stall;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr, if_pc, if_pc_plus4;

  logic        w_req, w_rvalid, w_valid;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_pc4;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .DEPTH     (DEPTH),
    .NOP_INSTR (NOP)
  ) dut (
    .clk (clk), .rst (rst),
    .imem_req (imem_req), .imem_addr (imem_addr), .imem_ready (imem_ready),
    .imem_rvalid (imem_rvalid), .imem_rdata (imem_rdata),
    .redirect_valid (redirect_valid), .redirect_pc (redirect_pc), .stall (stall),
    .if_valid (if_valid), .if_instr (if_instr), .if_pc (if_pc), .if_pc_plus4 (if_pc_plus4)
  );

  fetch_unit #(
    .RESET_PC  (32'hFFFF_FFF8),
    .DEPTH     (DEPTH),
    .NOP_INSTR (NOP)
  ) dut_wrap (
    .clk (clk), .rst (rst),
    .imem_req (w_req), .imem_addr (w_addr), .imem_ready (1'b1),
    .imem_rvalid (w_rvalid), .imem_rdata (w_rdata),
    .redirect_valid (1'b0), .redirect_pc (32'h0), .stall (1'b0),
    .if_valid (w_valid), .if_instr (w_instr), .if_pc (w_pc), .if_pc_plus4 (w_pc4)
  );

  typedef struct { logic [31:0] addr; int due; } rsp_t;
  rsp_t        memq[$];
  logic [31:0] vlog[$];
  int          vcyc[$];
  logic [31:0] wq[$];

  int          cyc, lat, first_valid, delivered, acc_count;
  logic [3:0]  ready_pat;
  logic [31:0] exp_pc;
  logic        collect_w;
  logic        p_redirect, p_stall, p_req, p_ready, p_valid;
  logic [31:0] p_target, p_addr, p_instr, p_pc, p_pc4;
  logic        w_pend, w_acc;
  logic [31:0] w_pend_addr, w_acc_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ {a[15:0], a[31:16]} ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = '0; imem_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
    w_rvalid = 1'b0; w_rdata = '0;
    memq.delete(); w_pend = 1'b0; w_pend_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0; first_valid = -1; exp_pc = 32'h0;
    vlog.delete(); vcyc.delete();
  endtask

  // Called just after a rising edge: drives one cycle of inputs, crosses the
  // next edge and checks the outputs it produced.
  task automatic cycle(input logic redir, input logic [31:0] tgt, input logic stl);
    logic rv;
    int   outstanding;
    rv = (memq.size() > 0) && (memq[0].due <= cyc);
    imem_rvalid    = rv;
    imem_rdata     = rv ? mem_word(memq[0].addr) : 32'hDEAD_BEEF;
    imem_ready     = ready_pat[cyc % 4];
    redirect_valid = redir;
    redirect_pc    = tgt;
    stall          = stl;
    w_rvalid       = w_pend;
    w_rdata        = mem_word(w_pend_addr);
    #1;
    p_req = imem_req; p_ready = imem_ready; p_addr = imem_addr;
    p_redirect = redir; p_target = tgt; p_stall = stl;
    p_valid = if_valid; p_instr = if_instr; p_pc = if_pc; p_pc4 = if_pc_plus4;
    if (imem_req) check("addr_align", 32'(imem_addr[1:0]), 32'd0);
    w_acc = w_req; w_acc_addr = w_addr;

    @(posedge clk);
    cyc++;
    #1;
    outstanding = memq.size();
    if (rv) void'(memq.pop_front());
    if (p_req && p_ready) begin
      acc_count++;
      check("live_bound", 32'(outstanding < DEPTH), 32'd1);
      memq.push_back('{p_addr, cyc + lat - 1});
    end

    if (p_redirect) begin
      check("redir_valid", 32'(if_valid), 32'd0);
      check("redir_instr", if_instr, NOP);
      check("redir_pc_hold", if_pc, p_pc);
      exp_pc = p_target & 32'hFFFF_FFFC;
    end else if (p_stall) begin
      check("stall_valid", 32'(if_valid), 32'(p_valid));
      check("stall_instr", if_instr, p_instr);
      check("stall_pc", if_pc, p_pc);
      check("stall_pc4", if_pc_plus4, p_pc4);
    end else if (if_valid) begin
      check("stream_pc", if_pc, exp_pc);
      check("stream_instr", if_instr, mem_word(exp_pc));
      check("stream_pc4", if_pc_plus4, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      delivered++;
      vlog.push_back(if_pc);
      vcyc.push_back(cyc);
      if (first_valid < 0) first_valid = cyc;
    end else begin
      check("bubble_instr", if_instr, NOP);
      check("bubble_pc_hold", if_pc, p_pc);
    end

    if (p_req && !p_ready && !p_redirect) begin
      check("req_held", 32'(imem_req), 32'd1);
      check("addr_held", imem_addr, p_addr);
    end

    w_pend = w_acc; w_pend_addr = w_acc_addr;
    if (collect_w && w_valid) begin
      wq.push_back(w_pc);
      check("wrap_instr", w_instr, mem_word(w_pc));
      check("wrap_pc4", w_pc4, w_pc + 32'd4);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    delivered = 0; acc_count = 0; lat = 1; ready_pat = 4'b1111; collect_w = 1'b1;
    apply_reset();

    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_instr", if_instr, NOP);
    check("rst_pc", if_pc, 32'h0);
    check("rst_pc4", if_pc_plus4, 32'h4);
    check("rst_req", 32'(imem_req), 32'd0);

    // Zero-wait streaming
    repeat (5) cycle(1'b0, 32'h0, 1'b0);
    check("t1_first_valid_cycle", 32'(first_valid), 32'd3);
    check("t1_count", 32'(vlog.size()), 32'd3);
    if (vlog.size() >= 3) begin
      check("t1_pc0", vlog[0], 32'h0); check("t1_cyc0", 32'(vcyc[0]), 32'd3);
      check("t1_pc1", vlog[1], 32'h4); check("t1_cyc1", 32'(vcyc[1]), 32'd4);
      check("t1_pc2", vlog[2], 32'h8); check("t1_cyc2", 32'(vcyc[2]), 32'd5);
    end
    check("wrap_count", 32'(wq.size() >= 3), 32'd1);
    if (wq.size() >= 3) begin
      check("wrap_pc0", wq[0], 32'hFFFF_FFF8);
      check("wrap_pc1", wq[1], 32'hFFFF_FFFC);
      check("wrap_pc2", wq[2], 32'h0000_0000);
    end
    collect_w = 1'b0;

    // Stall for 4 cycles while the memory keeps streaming
    acc_count = 0;
    repeat (4) cycle(1'b0, 32'h0, 1'b1);
    check("t2_frozen_pc", if_pc, 32'h8);
    check("t2_acc_bound", 32'(acc_count <= 2), 32'd1);
    vlog.delete();
    repeat (2) cycle(1'b0, 32'h0, 1'b0);
    check("t2_release_count", 32'(vlog.size()), 32'd2);
    if (vlog.size() >= 2) begin
      check("t2_pc_c", vlog[0], 32'hC);
      check("t2_pc_10", vlog[1], 32'h10);
    end

    // Redirect with two requests in flight
    lat = 3;
    for (int i = 0; i < 20 && memq.size() != 2; i++) cycle(1'b0, 32'h0, 1'b0);
    check("t3_two_inflight", 32'(memq.size()), 32'd2);
    cycle(1'b1, 32'h100, 1'b0);
    vlog.delete();
    for (int i = 0; i < 30 && vlog.size() == 0; i++) cycle(1'b0, 32'h0, 1'b0);
    check("t3_got_valid", 32'(vlog.size() > 0), 32'd1);
    if (vlog.size() > 0) check("t3_first_pc", vlog[0], 32'h100);
    repeat (8) cycle(1'b0, 32'h0, 1'b0);

    // Redirect coinciding with a response and a stall
    lat = 2;
    for (int i = 0; i < 20 && !((memq.size() > 0) && (memq[0].due <= cyc)); i++)
      cycle(1'b0, 32'h0, 1'b0);
    check("t4_rvalid_due", 32'((memq.size() > 0) && (memq[0].due <= cyc)), 32'd1);
    cycle(1'b1, 32'h203, 1'b1);
    check("t4_addr", imem_addr, 32'h200);
    check("t4_bubble", 32'(if_valid), 32'd0);
    vlog.delete();
    for (int i = 0; i < 30 && vlog.size() == 0; i++) cycle(1'b0, 32'h0, 1'b0);
    check("t4_got_valid", 32'(vlog.size() > 0), 32'd1);
    if (vlog.size() > 0) check("t4_first_pc", vlog[0], 32'h200);

    // ready toggling, latency 3, occasional stall and one redirect
    ready_pat = 4'b0101; lat = 3;
    delivered = 0;
    for (int i = 0; i < 32; i++)
      cycle(i == 16, 32'h400, (i % 7) == 3);
    check("t5_progress", 32'(delivered >= 5), 32'd1);

    // Async reset mid-stream
    ready_pat = 4'b1111; lat = 1;
    repeat (6) cycle(1'b0, 32'h0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(if_valid), 32'd0);
    check("arst_instr", if_instr, NOP);
    check("arst_pc", if_pc, 32'h0);
    check("arst_pc4", if_pc_plus4, 32'h4);
    check("arst_req", 32'(imem_req), 32'd0);
    check("arst_addr", imem_addr, 32'h0);
    apply_reset();
    repeat (5) cycle(1'b0, 32'h0, 1'b0);
    check("t6_first_valid_cycle", 32'(first_valid), 32'd3);
    if (vlog.size() > 0) check("t6_first_pc", vlog[0], 32'h0);
    else check("t6_got_valid", 32'd0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage of the 5-stage RV32I pipeline, directly upstream of decode. Generates the PC and issues in-order word reads to instruction memory over a valid/ready request channel, tolerating variable response latency. Buffers returned words in a small queue and presents {instruction, PC} to the IF/ID boundary, honouring decode stalls and EX-stage redirects (branch taken, JAL, JALR).

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
DEPTH, 2, queue entries and maximum outstanding imem requests (power of two, >=2).
NOP_INSTR, 32'h0000_0013, instruction presented on a bubble (ADDI x0,x0,0).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
imem_req  output  1  request valid.
imem_addr  output  32  word address (bits [1:0] always 0).
imem_ready  input  1  memory accepts the request this cycle.
imem_rvalid  input  1  response valid; responses return in request order.
imem_rdata  input  32  response instruction word.
redirect_valid  input  1  one-cycle pulse from EX: control-flow change.
redirect_pc  input  32  target PC; bits [1:0] forced to 0 internally.
stall  input  1  hazard unit: hold the IF/ID output.
if_valid  output  1  if_instr/if_pc hold a real instruction.
if_instr  output  32  instruction to the decode/control unit.
if_pc  output  32  PC of if_instr.
if_pc_plus4  output  32  if_pc + 4, used for the JAL/JALR link value.

Behaviour:
- Reset (async assert): pc_q=RESET_PC, queue empty, live=0, discard=0, state=BOOT, if_valid=0, if_instr=NOP_INSTR, if_pc=RESET_PC, if_pc_plus4=RESET_PC+4, imem_req=0.
- FSM: BOOT -> RUN unconditionally on the first clock after reset deasserts. imem_req is 0 in BOOT. There is no other state. Reset mid-operation returns to BOOT; responses still in flight at that point belong to the memory's reset domain.
- Issue: imem_req = RUN && (qcount + live < DEPTH) && (live + discard < DEPTH); imem_addr = pc_q.
- Handshake: on imem_req && imem_ready, pc_q += 4 (32-bit wrap; 0xFFFF_FFFC -> 0x0000_0000) and live++. imem_req and imem_addr stay stable until accepted, unless a redirect occurs.
- Response: on imem_rvalid, if discard>0 then discard-- and drop the word. Otherwise live-- and the word is tagged with the PC recorded at issue (a tag FIFO of DEPTH entries).
- Output register, on a cycle without redirect:
  - !stall and queue non-empty: load the queue head and pop it.
  - !stall, queue empty and a live response arrives: bypass directly into the output register. Latency imem_rvalid -> if_valid is 1 cycle.
  - !stall and nothing available: bubble (if_valid=0, if_instr=NOP_INSTR; if_pc holds its value).
  - stall: output holds; live responses enqueue. The credit rule guarantees there is no overflow.
- Redirect (priority over stall and over every other event):
  - Next cycle pc_q = {redirect_pc[31:2],2'b00}.
  - Queue cleared; output becomes a bubble.
  - discard += live, including any request accepted or response consumed in the same cycle (same-cycle rvalid is dropped). live = 0.
  - The new request may issue on the following cycle, without waiting for discards to drain.
- Back-to-back redirects: each flushes; the discard count accumulates and never exceeds DEPTH.
- if_pc_plus4 is registered together with if_pc.

Decomposition:
- Package riscv_pkg: XLEN=32, NOP_INSTR, RESET_PC default, opcode constants shared with the control unit.
- One sub-module, fetch_queue: a synchronous DEPTH-entry FIFO of {pc,instr} with push, pop, clear, count, full and empty. Clear has priority over push.

Test Plan:
- Zero-wait memory (ready=1, rvalid one cycle after accept), no stall -> if_pc sequence 0x0,0x4,0x8 on consecutive cycles with if_valid=1; first if_valid=1 at cycle 3 after reset deasserts.
- Stall held 4 cycles with the memory streaming -> output frozen at pc 0x8; at most 2 further requests accepted; pcs 0xC,0x10 emerge in order on release; no loss or duplication.
- Redirect to 0x100 while 2 requests are in flight -> both late responses dropped; the next if_valid instruction has if_pc=0x100; no stale pcs appear.
- Redirect in the same cycle as imem_rvalid and stall=1 -> the word is dropped, the output becomes a bubble, the next request addr is 0x200; redirect_pc=0x203 gives imem_addr=0x200.
- ready toggling 1010 with rvalid latency 3 -> imem_addr held stable while unaccepted; the instruction stream stays in order; live never exceeds 2.
- RESET_PC=0xFFFF_FFF8, streaming -> pcs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; async rst asserted mid-stream -> outputs return to reset values immediately, without waiting for a clock edge.
